// File: rtl/btn_debounce_latch_pkg.sv
// Shared definitions for the write-button debounce/latch stage.
// Holds the FSM state encoding and the default debounce constants.
// Retune DefDebounceCycles here when the clock rate changes.
package btn_debounce_latch_pkg;

   // 10 ms at 50 MHz
   localparam int unsigned DefDebounceCycles = 500000;
   localparam int unsigned DefCntW           = 24;

   typedef enum logic [1:0] {
      StIdle        = 2'b00,
      StPressWait   = 2'b01,
      StPressed     = 2'b10,
      StReleaseWait = 2'b11
   } state_e;

endpackage

// File: rtl/btn_debounce_latch_sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs.
// Ports:
//   clk_i  - destination clock
//   rst_i  - asynchronous active-high reset, clears both stages
//   d_i    - asynchronous input bus (each bit synchronised independently)
//   q_o    - synchronised output, two clk_i edges behind d_i
module sync_2ff #(
   parameter int unsigned Width = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [Width-1:0] d_i,
   output logic [Width-1:0] q_o
);

   logic [Width-1:0] meta_q;
   logic [Width-1:0] sync_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/btn_debounce_latch.sv
// Write-button debounce and character latch for the LCD text path.
// A press is accepted after DEBOUNCE_CYCLES consecutive high synchronised
// samples; the switch byte is then captured, prell_flag rises and
// press_pulse strobes for one cycle. prell_flag drops only after
// DEBOUNCE_CYCLES consecutive low samples.
// Ports:
//   clk         - system clock
//   reset       - asynchronous active-high reset
//   btn_raw     - raw bouncing write button (async)
//   sw          - character switches (async, quasi-static)
//   data_btn    - character code captured on the accepted press
//   prell_flag  - debounced "button held" level
//   press_pulse - one-cycle strobe on the cycle prell_flag rises
module btn_debounce_latch
   import btn_debounce_latch_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
   parameter int unsigned CNT_W           = DefCntW
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_raw,
   input  logic [7:0] sw,
   output logic [7:0] data_btn,
   output logic       prell_flag,
   output logic       press_pulse
);

   // The sample that moves IDLE->PRESS_WAIT (or PRESSED->RELEASE_WAIT) is the
   // first stable sample, so the wait state needs DEBOUNCE_CYCLES-1 more and
   // finishes when cnt reaches DEBOUNCE_CYCLES-2. This gives the
   // DEBOUNCE_CYCLES+2 edge latency from a clean input change.
   localparam logic [CNT_W-1:0] LastCnt = CNT_W'(DEBOUNCE_CYCLES - 2);

   logic       btn_s;
   logic [7:0] sw_s;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       data_q, data_d;
   logic             flag_q, flag_d;
   logic             pulse_q, pulse_d;

   sync_2ff #(.Width(1)) u_sync_btn (
      .clk_i (clk),
      .rst_i (reset),
      .d_i   (btn_raw),
      .q_o   (btn_s)
   );

   sync_2ff #(.Width(8)) u_sync_sw (
      .clk_i (clk),
      .rst_i (reset),
      .d_i   (sw),
      .q_o   (sw_s)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         data_q  <= 8'h00;
         flag_q  <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         flag_q  <= flag_d;
         pulse_q <= pulse_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      flag_d  = flag_q;
      pulse_d = 1'b0;
      case (state_q)
         StIdle: begin
            if (btn_s) begin
               state_d = StPressWait;
               cnt_d   = '0;
            end
         end
         StPressWait: begin
            if (!btn_s) begin
               state_d = StIdle;
            end else if (cnt_q == LastCnt) begin
               state_d = StPressed;
               data_d  = sw_s;
               flag_d  = 1'b1;
               pulse_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StPressed: begin
            if (!btn_s) begin
               state_d = StReleaseWait;
               cnt_d   = '0;
            end
         end
         StReleaseWait: begin
            // A glitch back high returns to PRESSED without a new capture.
            if (btn_s) begin
               state_d = StPressed;
               cnt_d   = '0;
            end else if (cnt_q == LastCnt) begin
               state_d = StIdle;
               flag_d  = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign data_btn    = data_q;
   assign prell_flag  = flag_q;
   assign press_pulse = pulse_q;

endmodule

// File: tb/tb_btn_debounce_latch.sv
module tb_btn_debounce_latch;

   localparam int unsigned D = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       btn_raw;
   logic [7:0] sw;
   logic [7:0] data_btn;
   logic       prell_flag;
   logic       press_pulse;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: a 2-sample delay line, then "the level flips once D
   // consecutive samples disagree with it".
   logic       btn_pipe[$];
   logic [7:0] sw_pipe[$];
   logic       flag_m;
   logic       pulse_m;
   logic [7:0] data_m;
   int         run_m;
   logic       pulse_prev;
   int         pulse_count;

   btn_debounce_latch #(
      .DEBOUNCE_CYCLES (D),
      .CNT_W           (24)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .btn_raw     (btn_raw),
      .sw          (sw),
      .data_btn    (data_btn),
      .prell_flag  (prell_flag),
      .press_pulse (press_pulse)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      btn_pipe.delete();
      sw_pipe.delete();
      btn_pipe.push_back(1'b0);
      btn_pipe.push_back(1'b0);
      sw_pipe.push_back(8'h00);
      sw_pipe.push_back(8'h00);
      flag_m  = 1'b0;
      pulse_m = 1'b0;
      data_m  = 8'h00;
      run_m   = 0;
   endtask

   task automatic model_edge();
      logic       s;
      logic [7:0] w;
      s = btn_pipe.pop_front();
      w = sw_pipe.pop_front();
      btn_pipe.push_back(btn_raw);
      sw_pipe.push_back(sw);
      pulse_m = 1'b0;
      if (s != flag_m) run_m++;
      else run_m = 0;
      if (run_m == int'(D)) begin
         flag_m = s;
         run_m  = 0;
         if (s) begin
            pulse_m = 1'b1;
            data_m  = w;
         end
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, "_flag"}, {7'b0, prell_flag}, {7'b0, flag_m});
      check({tag, "_pulse"}, {7'b0, press_pulse}, {7'b0, pulse_m});
      check({tag, "_data"}, data_btn, data_m);
      check({tag, "_pulse_twice"}, {7'b0, pulse_prev & press_pulse}, 8'h00);
      pulse_prev = press_pulse;
      if (press_pulse === 1'b1) pulse_count++;
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      if (reset) model_reset();
      else model_edge();
      #1;
      check_model(tag);
   endtask

   task automatic ticks(input string tag, input int n);
      for (int i = 0; i < n; i++) tick(tag);
   endtask

   int pc0;

   initial begin
      reset       = 1'b1;
      btn_raw     = 1'b0;
      sw          = 8'h00;
      pulse_prev  = 1'b0;
      pulse_count = 0;
      model_reset();

      // 1. Reset
      ticks("t1_rst", 3);
      check("t1_data", data_btn, 8'h00);
      check("t1_flag", {7'b0, prell_flag}, 8'h00);
      check("t1_pulse", {7'b0, press_pulse}, 8'h00);
      reset = 1'b0;
      ticks("t1_idle", 20);
      check("t1_idle_flag", {7'b0, prell_flag}, 8'h00);

      // 2. Clean press and release
      sw      = 8'h41;
      btn_raw = 1'b1;
      pc0     = pulse_count;
      for (int i = 1; i <= 5; i++) begin
         tick("t2_rise");
         check("t2_flag_early", {7'b0, prell_flag}, 8'h00);
      end
      tick("t2_rise");
      check("t2_flag_edge6", {7'b0, prell_flag}, 8'h01);
      check("t2_pulse_edge6", {7'b0, press_pulse}, 8'h01);
      check("t2_data", data_btn, 8'h41);
      ticks("t2_hold", 14);
      check("t2_one_pulse", 8'(pulse_count - pc0), 8'h01);
      btn_raw = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         tick("t2_fall");
         check("t2_flag_held", {7'b0, prell_flag}, 8'h01);
      end
      tick("t2_fall");
      check("t2_flag_fall6", {7'b0, prell_flag}, 8'h00);
      check("t2_data_kept", data_btn, 8'h41);
      ticks("t2_idle", 5);

      // 3. Bouncy press
      pc0 = pulse_count;
      for (int b = 0; b < 4; b++) begin
         btn_raw = ~b[0];
         ticks("t3_bounce", 2);
         check("t3_no_flag", {7'b0, prell_flag}, 8'h00);
      end
      btn_raw = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         tick("t3_rise");
         check("t3_flag_early", {7'b0, prell_flag}, 8'h00);
      end
      tick("t3_rise");
      check("t3_flag_edge6", {7'b0, prell_flag}, 8'h01);
      ticks("t3_hold", 4);
      check("t3_one_pulse", 8'(pulse_count - pc0), 8'h01);

      // 4. Release glitch, then switch change while held
      pc0     = pulse_count;
      btn_raw = 1'b0;
      ticks("t4_glitch", 2);
      btn_raw = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick("t4_after");
         check("t4_flag_stays", {7'b0, prell_flag}, 8'h01);
      end
      check("t4_no_pulse", 8'(pulse_count - pc0), 8'h00);
      sw = 8'h42;
      ticks("t4_sw", 8);
      check("t4_data_held", data_btn, 8'h41);
      btn_raw = 1'b0;
      ticks("t4_release", 10);

      // 5. Short press
      btn_raw = 1'b1;
      ticks("t5_short", 3);
      btn_raw = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick("t5_after");
         check("t5_no_flag", {7'b0, prell_flag}, 8'h00);
      end
      check("t5_data", data_btn, 8'h41);

      // 6. Reset mid-operation, re-accept, then a fresh press
      sw      = 8'h37;
      btn_raw = 1'b1;
      ticks("t6_press", 10);
      check("t6_flag_up", {7'b0, prell_flag}, 8'h01);
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      check("t6_async_flag", {7'b0, prell_flag}, 8'h00);
      check("t6_async_data", data_btn, 8'h00);
      check("t6_async_pulse", {7'b0, press_pulse}, 8'h00);
      ticks("t6_inrst", 2);
      reset = 1'b0;
      pc0   = pulse_count;
      for (int i = 1; i <= 5; i++) begin
         tick("t6_reacq");
         check("t6_flag_early", {7'b0, prell_flag}, 8'h00);
      end
      tick("t6_reacq");
      check("t6_flag_edge6", {7'b0, prell_flag}, 8'h01);
      check("t6_data_cur", data_btn, 8'h37);
      btn_raw = 1'b0;
      ticks("t6_rel", 10);
      sw      = 8'h5A;
      btn_raw = 1'b1;
      ticks("t6_press2", 10);
      check("t6_data_5a", data_btn, 8'h5A);
      check("t6_two_pulses", 8'(pulse_count - pc0), 8'h02);
      btn_raw = 1'b0;
      ticks("t6_rel2", 10);

      // Randomised button runs and switch values against the model
      for (int seg = 0; seg < 60; seg++) begin
         btn_raw = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) sw = 8'($urandom);
         ticks("rnd", $urandom_range(1, 9));
      end
      btn_raw = 1'b0;
      ticks("rnd_tail", 10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
